// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//
// Shared definitions for the bit-serial adder controller:
//   - state_t : controller state encoding (IDLE / RUN / DONE)
//   - clog2   : ceiling log2, used to size the bit counter
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Ceiling log2 of value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_fa_mux_cell.sv
// -----------------------------------------------------------------------------
// fa_mux_cell
//
// One-bit full adder built from two 4:1 multiplexers. The operand bits form
// the shared select {a, b}; the carry-in (or its inverse, or a constant) is
// steered onto the data inputs.
//
// Ports:
//   a   in  operand A bit
//   b   in  operand B bit
//   c   in  carry in
//   s   out sum bit      = a ^ b ^ c
//   co  out carry out    = majority(a, b, c)
// -----------------------------------------------------------------------------
module fa_mux_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  // Plain 4:1 mux; d[sel] with d[0] selected by sel = 2'b00.
  function automatic logic mux4(input logic [1:0] sel, input logic [3:0] d);
    logic y;
    case (sel)
      2'b00:   y = d[0];
      2'b01:   y = d[1];
      2'b10:   y = d[2];
      default: y = d[3];
    endcase
    return y;
  endfunction

  logic [1:0] sel;
  logic [3:0] sum_d;
  logic [3:0] carry_d;

  assign sel = {a, b};

  // Sum: operands equal -> pass c; operands differ -> invert c.
  assign sum_d   = {c, ~c, ~c, c};
  // Carry: 00 -> 0, one operand set -> propagate c, 11 -> generate.
  assign carry_d = {1'b1, c, c, 1'b0};

  assign s  = mux4(sel, sum_d);
  assign co = mux4(sel, carry_d);

endmodule : fa_mux_cell

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. On an accepted start the operands are latched
// into right-shifting registers and the carry flip-flop is loaded with cin.
// Each RUN cycle feeds the operand LSBs and the carry through one mux-built
// full-adder cell; the sum bit enters the MSB of a result shift register.
// After WIDTH bits the completed result and final carry are published on
// sum / cout together with a one-cycle done pulse.
//
// A new operation is accepted every WIDTH+2 cycles at best
// (accept, WIDTH bit cycles, one DONE cycle back to IDLE).
//
// Parameters:
//   WIDTH  operand / sum width, 2..32
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request a new addition (honoured only in IDLE)
//   a, b   in   operands, sampled on the accepting edge
//   cin    in   carry in, sampled on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle completion pulse
//   sum    out  result of last completed addition
//   cout   out  carry out of last completed addition
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic             busy_d;
  logic             done_d;
  logic             load;
  logic             step;
  logic             finish;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             cell_s;
  logic             cell_co;

  fa_mux_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        // Unreachable encoding (2'b11): recover to IDLE without side effects.
        state_d = IDLE;
      end
    endcase
    // busy/done are registered from the next state so the outputs come
    // straight off flops and line up with the state they describe.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // ---------------------------------------------------------------------------
  // State and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial datapath: operand shifters, carry flop, counter, result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      a_sh    <= a;
      b_sh    <= b;
      res_sh  <= '0;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (step) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= {cell_s, res_sh[WIDTH-1:1]};
      carry_q <= cell_co;
      cnt_q   <= cnt_q + CW'(1);
      // On the last bit the result register has not yet absorbed the
      // current sum bit, so publish the shifted value directly.
      if (finish) begin
        sum  <= {cell_s, res_sh[WIDTH-1:1]};
        cout <= cell_co;
      end
    end
  end

endmodule : serial_adder_ctrl
